// File: rtl/xxx_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xxx_seq_pkg
// Shared definitions for the FFT front-end sequencing controller:
//   - seq_state_t : controller phase encoding (IDLE/WARMUP/ACTIVE/COOLDOWN)
//   - DEF_*       : default parameter values
//   - phase_cnt_w : width of the warm-up/cool-down phase counter
//   - frame_cnt_w : width of the modulo-FRAME_LEN frame counter
// ---------------------------------------------------------------------------
package xxx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARMUP   = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_WARMUP_CYC = 2;
  localparam int DEF_COOL_CYC   = 2;
  localparam int DEF_FRAME_LEN  = 64;

  // One counter serves both timed phases, so it must hold the larger load.
  function automatic int phase_cnt_w(input int warm, input int cool);
    int m;
    m = (warm > cool) ? warm : cool;
    return $clog2(m) + 1;
  endfunction

  function automatic int frame_cnt_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/xxx_seq_ctrl_frame_cnt.sv
// ---------------------------------------------------------------------------
// xxx_frame_cnt
// Modulo-FRAME_LEN counter that tracks the position inside a frame while the
// controller is ACTIVE and flags the final valid cycle of each frame.
// Ports:
//   clk_cg_i : domain clock
//   rst_i    : asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable, high on every valid cycle
//   last     : high while en and the counter sits on FRAME_LEN-1
// ---------------------------------------------------------------------------
module xxx_frame_cnt
  import xxx_seq_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic clk_cg_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int FW = frame_cnt_w(FRAME_LEN);
  localparam logic [FW-1:0] LAST_VAL = FW'(FRAME_LEN - 1);

  logic [FW-1:0] fcnt;

  always_ff @(posedge clk_cg_i or posedge rst_i) begin
    if (rst_i) begin
      fcnt <= '0;
    end else if (clr) begin
      fcnt <= '0;
    end else if (en) begin
      fcnt <= (fcnt == LAST_VAL) ? '0 : fcnt + FW'(1);
    end
  end

  assign last = en & (fcnt == LAST_VAL);

endmodule

// File: rtl/xxx_seq_ctrl.sv
// ---------------------------------------------------------------------------
// xxx_seq_ctrl
// Front-end sequencing controller for the FFT datapath. Opens the downstream
// clock gate, waits WARMUP_CYC cycles, then asserts per-channel data valid on
// the mask captured at activation, pulses frame_last_o every FRAME_LEN valid
// cycles, and keeps the clock running for COOL_CYC cycles after enable drops.
// Ports:
//   clk_cg_i       : free-running clock, upstream of the ICG
//   rst_i          : asynchronous active-high reset
//   dft_tm_i       : test mode, forces enb_cg_o high
//   xxx_en_i       : level enable request
//   ch_mask_i      : channel select, captured on activation
//   enb_cg_o       : clock-gate enable for downstream ICG cells
//   xxx_dt_valid_o : per-channel data valid
//   frame_last_o   : pulse on the last valid cycle of each frame
//   busy_o         : controller not idle
// ---------------------------------------------------------------------------
module xxx_seq_ctrl
  import xxx_seq_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int COOL_CYC   = DEF_COOL_CYC,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic              clk_cg_i,
  input  logic              rst_i,
  input  logic              dft_tm_i,
  input  logic              xxx_en_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic              enb_cg_o,
  output logic [NUM_CH-1:0] xxx_dt_valid_o,
  output logic              frame_last_o,
  output logic              busy_o
);

  localparam int CNT_W = phase_cnt_w(WARMUP_CYC, COOL_CYC);
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic is_active;
  logic frame_clr;
  logic frame_last;
  logic start_req;

  // A request with an empty mask would produce a warm-up with nothing to
  // enable, so it is treated as no request at all.
  assign start_req = xxx_en_i & (|ch_mask_i);

  always_ff @(posedge clk_cg_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = WARMUP;
          cnt_d   = WARM_LOAD;
          mask_d  = ch_mask_i;
        end
      end
      WARMUP: begin
        // Aborting warm-up skips cool-down: no valid data ever left.
        if (!xxx_en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!xxx_en_i) begin
          state_d = COOLDOWN;
          cnt_d   = COOL_LOAD;
        end
      end
      COOLDOWN: begin
        // A fresh request restarts warm-up rather than finishing the flush.
        if (start_req) begin
          state_d = WARMUP;
          cnt_d   = WARM_LOAD;
          mask_d  = ch_mask_i;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end
    endcase
  end

  assign is_active = (state_q == ACTIVE);

  // Hold the frame position at zero outside ACTIVE and on the exit edge, so a
  // re-activation always starts a fresh frame.
  assign frame_clr = !is_active || (state_d != ACTIVE);

  xxx_frame_cnt #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_cnt (
    .clk_cg_i (clk_cg_i),
    .rst_i    (rst_i),
    .clr      (frame_clr),
    .en       (is_active),
    .last     (frame_last)
  );

  assign busy_o         = (state_q == WARMUP) || (state_q == ACTIVE) || (state_q == COOLDOWN);
  assign xxx_dt_valid_o = is_active ? mask_q : '0;
  assign frame_last_o   = frame_last;

  // Combinational so the downstream clock starts in the same cycle as the
  // request; reset masks everything but test mode.
  assign enb_cg_o = dft_tm_i | (~rst_i & (xxx_en_i | busy_o));

endmodule

// File: tb/tb_xxx_seq_ctrl.sv
module tb_xxx_seq_ctrl;

  localparam int NUM_CH     = 4;
  localparam int WARMUP_CYC = 2;
  localparam int COOL_CYC   = 2;
  localparam int FRAME_LEN  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              dft;
  logic              en;
  logic [NUM_CH-1:0] mask;
  logic              enb;
  logic [NUM_CH-1:0] valid;
  logic              last;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase flags plus elapsed-cycle counts.
  bit              m_warm, m_act, m_cool;
  int              m_warm_n, m_cool_n, m_act_n;
  logic [NUM_CH-1:0] m_mask;

  xxx_seq_ctrl #(
    .NUM_CH     (NUM_CH),
    .WARMUP_CYC (WARMUP_CYC),
    .COOL_CYC   (COOL_CYC),
    .FRAME_LEN  (FRAME_LEN)
  ) dut (
    .clk_cg_i       (clk),
    .rst_i          (rst),
    .dft_tm_i       (dft),
    .xxx_en_i       (en),
    .ch_mask_i      (mask),
    .enb_cg_o       (enb),
    .xxx_dt_valid_o (valid),
    .frame_last_o   (last),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_warm = 0; m_act = 0; m_cool = 0;
    m_warm_n = 0; m_cool_n = 0; m_act_n = 0;
    m_mask = '0;
  endtask

  task automatic model_step();
    if (m_warm) begin
      if (!en) m_warm = 0;
      else if (m_warm_n + 1 >= WARMUP_CYC) begin m_warm = 0; m_act = 1; m_act_n = 0; end
      else m_warm_n++;
    end else if (m_act) begin
      if (!en) begin m_act = 0; m_cool = 1; m_cool_n = 0; end
      else m_act_n++;
    end else if (m_cool) begin
      if (en && mask != 0) begin m_cool = 0; m_warm = 1; m_warm_n = 0; m_mask = mask; end
      else if (m_cool_n + 1 >= COOL_CYC) m_cool = 0;
      else m_cool_n++;
    end else if (en && mask != 0) begin
      m_warm = 1; m_warm_n = 0; m_mask = mask;
    end
  endtask

  // Advance one clock edge and leave time 1 unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; dft = 1'b0; en = 1'b0; mask = '0;
    #7;
    checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", valid, 4'b0000); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=%b", last, 1'b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b exp=%b", enb, 1'b0); end
    dft = 1'b1;
    #1;
    checks++; if (enb !== 1'b1) begin failures++; $display("FAIL reset_enb_dft got=%b exp=%b", enb, 1'b1); end
    dft = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_startup();
    @(negedge clk);
    en = 1'b1; mask = 4'b0101;
    #1;
    checks++; if (enb !== 1'b1) begin failures++; $display("FAIL start_enb_same_cycle got=%b exp=%b", enb, 1'b1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_busy_pre got=%b exp=%b", busy, 1'b0); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      mask = 4'($urandom_range(0, 15)); // must be ignored once captured
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy edge=%0d got=%b exp=%b", k, busy, 1'b1); end
      checks++;
      if (valid !== ((k >= 3) ? 4'b0101 : 4'b0000)) begin
        failures++; $display("FAIL start_valid edge=%0d got=%b exp=%b", k, valid, (k >= 3) ? 4'b0101 : 4'b0000);
      end
    end
  endtask

  task automatic test_frames();
    int vcount;
    vcount = 1;
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL frame_first_last got=%b exp=%b", last, 1'b0); end
    for (int i = 0; i < 129; i++) begin
      tick();
      if (valid === 4'b0101) vcount++;
      checks++;
      if (last !== ((vcount == 64) || (vcount == 128))) begin
        failures++; $display("FAIL frame_last vcycle=%0d got=%b exp=%b", vcount, last, (vcount == 64) || (vcount == 128));
      end
    end
    checks++; if (vcount != 130) begin failures++; $display("FAIL frame_valid_count got=%0d exp=%0d", vcount, 130); end
  endtask

  task automatic test_cooldown();
    en = 1'b0;
    tick();
    checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL cool_valid got=%b exp=%b", valid, 4'b0000); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL cool_last got=%b exp=%b", last, 1'b0); end
    checks++; if (enb !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL cool_c1 got=enb%b/busy%b exp=enb1/busy1", enb, busy); end
    tick();
    checks++; if (enb !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL cool_c2 got=enb%b/busy%b exp=enb1/busy1", enb, busy); end
    tick();
    checks++; if (enb !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cool_end got=enb%b/busy%b exp=enb0/busy0", enb, busy); end
  endtask

  task automatic test_warmup_abort();
    en = 1'b1; mask = 4'b0011;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_warm_busy got=%b exp=%b", busy, 1'b1); end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || valid !== 4'b0000 || enb !== 1'b0) begin
        failures++; $display("FAIL abort_idle k=%0d got=busy%b/valid%b/enb%b exp=busy0/valid0000/enb0", k, busy, valid, enb);
      end
    end
  endtask

  task automatic test_reenter();
    en = 1'b1; mask = 4'b0110;
    repeat (4) tick();
    checks++; if (valid !== 4'b0110) begin failures++; $display("FAIL reenter_first got=%b exp=%b", valid, 4'b0110); end
    en = 1'b0;
    tick();
    en = 1'b1; mask = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (valid !== ((k == 3) ? 4'b1000 : 4'b0000) || busy !== 1'b1) begin
        failures++; $display("FAIL reenter_valid k=%0d got=%b/busy%b exp=%b/busy1", k, valid, busy, (k == 3) ? 4'b1000 : 4'b0000);
      end
    end
    en = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reenter_drain got=%b exp=%b", busy, 1'b0); end
    en = 1'b1; mask = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || valid !== 4'b0000 || enb !== 1'b1) begin
        failures++; $display("FAIL zero_mask k=%0d got=busy%b/valid%b/enb%b exp=busy0/valid0000/enb1", k, busy, valid, enb);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_dft();
    dft = 1'b1; en = 1'b0;
    repeat (2) tick();
    checks++; if (enb !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL dft_idle got=enb%b/busy%b exp=enb1/busy0", enb, busy); end
    en = 1'b1; mask = 4'b0010;
    repeat (3) tick();
    checks++; if (valid !== 4'b0010) begin failures++; $display("FAIL dft_run got=%b exp=%b", valid, 4'b0010); end
    en = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || enb !== 1'b1) begin failures++; $display("FAIL dft_drain got=busy%b/enb%b exp=busy0/enb1", busy, enb); end
    dft = 1'b0;
    #1;
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL dft_off got=%b exp=%b", enb, 1'b0); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mask = 4'b1111;
    repeat (3) tick();
    repeat (63) tick();
    checks++; if (last !== 1'b1 || valid !== 4'b1111) begin failures++; $display("FAIL arst_pre got=last%b/valid%b exp=last1/valid1111", last, valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 4'b0000 || last !== 1'b0 || busy !== 1'b0 || enb !== 1'b0) begin
      failures++; $display("FAIL arst_drop got=valid%b/last%b/busy%b/enb%b exp=0000/0/0/0", valid, last, busy, enb);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b0; dft = 1'b0; mask = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      mask = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 30) == 0) dft = ~dft;
      tick();
      checks++;
      if (busy !== (m_warm | m_act | m_cool)) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_warm | m_act | m_cool);
      end
      checks++;
      if (valid !== (m_act ? m_mask : 4'b0000)) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid, m_act ? m_mask : 4'b0000);
      end
      checks++;
      if (last !== (m_act && (m_act_n % FRAME_LEN == FRAME_LEN - 1))) begin
        failures++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", c, last, m_act && (m_act_n % FRAME_LEN == FRAME_LEN - 1));
      end
      checks++;
      if (enb !== (dft | en | m_warm | m_act | m_cool)) begin
        failures++; $display("FAIL rand_enb cyc=%0d got=%b exp=%b", c, enb, dft | en | m_warm | m_act | m_cool);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_frames();
    test_cooldown();
    test_warmup_abort();
    test_reenter();
    test_dft();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=expired exp=finished");
    $fatal(1, "timeout");
  end

endmodule
